// File: rtl/insn_sequencer_pkg.sv
// Shared constants for the multi-cycle core: opcodes, ALU ops, writeback selects,
// and the instruction sequencer state encoding plus decoded-control bundle.
package insn_sequencer_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic regwren;
    logic memren;
    logic memwren;
  } seq_ctl_t;

  localparam seq_ctl_t SEQ_CTL_NONE = '{regwren: 1'b0, memren: 1'b0, memwren: 1'b0};

  // A simultaneous read and write of data memory has no defined meaning.
  function automatic logic ctl_illegal(input seq_ctl_t c);
    return c.memren & c.memwren;
  endfunction

  function automatic logic ctl_is_mem(input seq_ctl_t c);
    return c.memren | c.memwren;
  endfunction

endpackage

// File: rtl/insn_sequencer_perf_cnt.sv
// Performance counters for the sequencer: free-running cycle count and retired
// instruction count, both wrapping modulo 2^DWIDTH.
module seq_perf_cnt #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              retire_i,
  output logic [DWIDTH-1:0] cycle_cnt_o,
  output logic [DWIDTH-1:0] retire_cnt_o
);

  localparam logic [DWIDTH-1:0] CNT_ONE  = {{(DWIDTH-1){1'b0}}, 1'b1};
  localparam logic [DWIDTH-1:0] CNT_ZERO = {DWIDTH{1'b0}};

  logic [DWIDTH-1:0] cycle_cnt_q;
  logic [DWIDTH-1:0] cycle_cnt_d;
  logic [DWIDTH-1:0] retire_cnt_q;
  logic [DWIDTH-1:0] retire_cnt_d;

  // Next counter values
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    if (retire_i) begin
      retire_cnt_d = retire_cnt_q + CNT_ONE;
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q  <= CNT_ZERO;
      retire_cnt_q <= CNT_ZERO;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt_o  = cycle_cnt_q;
  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: rtl/insn_sequencer.sv
// Multi-cycle instruction sequencer FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Define SEQ_PERF_CNT_EN to build in the cycle/retire performance counters.
module insn_sequencer
  import insn_sequencer_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_ready_i,
  input  logic              dmem_ready_i,
  input  logic              regwren_i,
  input  logic              memren_i,
  input  logic              memwren_i,
  output logic              imem_req_o,
  output logic              ir_we_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic              rf_we_o,
  output logic              pc_we_o,
  output logic              illegal_o,
  output logic [2:0]        state_o,
  output logic [DWIDTH-1:0] cycle_cnt_o,
  output logic [DWIDTH-1:0] retire_cnt_o
);

  seq_state_e state_q;
  seq_state_e state_d;
  seq_ctl_t   ctl_q;
  seq_ctl_t   ctl_d;

  // State and latched decode control
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ctl_q   <= SEQ_CTL_NONE;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  // Next-state logic; control is sampled only at the end of DECODE
  always_comb begin
    state_d = ST_FETCH;
    ctl_d   = ctl_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready_i) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXECUTE;
        ctl_d   = '{regwren: regwren_i, memren: memren_i, memwren: memwren_i};
      end
      ST_EXECUTE: begin
        if (ctl_illegal(ctl_q)) begin
          state_d = ST_FETCH;
        end else if (ctl_is_mem(ctl_q)) begin
          state_d = ST_MEMORY;
        end else if (ctl_q.regwren) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEMORY: begin
        if (!dmem_ready_i) begin
          state_d = ST_MEMORY;
        end else if (ctl_q.memwren) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Output decode; everything is held low during a reset cycle
  always_comb begin
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    illegal_o  = 1'b0;
    if (reset) begin
      imem_req_o = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          imem_req_o = 1'b1;
          ir_we_o    = imem_ready_i;
        end
        ST_DECODE: begin
          ir_we_o = 1'b0;
        end
        ST_EXECUTE: begin
          illegal_o = ctl_illegal(ctl_q);
          pc_we_o   = ctl_illegal(ctl_q) | (~ctl_is_mem(ctl_q) & ~ctl_q.regwren);
        end
        ST_MEMORY: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = ctl_q.memwren;
          pc_we_o    = dmem_ready_i & ctl_q.memwren;
        end
        ST_WRITEBACK: begin
          rf_we_o = ctl_q.regwren;
          pc_we_o = 1'b1;
        end
        default: begin
          pc_we_o = 1'b0;
        end
      endcase
    end
  end

  assign state_o = state_q;

`ifdef SEQ_PERF_CNT_EN
  seq_perf_cnt #(
    .DWIDTH(DWIDTH)
  ) u_perf_cnt (
    .clk         (clk),
    .reset       (reset),
    .retire_i    (pc_we_o),
    .cycle_cnt_o (cycle_cnt_o),
    .retire_cnt_o(retire_cnt_o)
  );
`else
  assign cycle_cnt_o  = {DWIDTH{1'b0}};
  assign retire_cnt_o = {DWIDTH{1'b0}};
`endif

endmodule
